// File: rtl/checksum_sched.sv
// checksum_sched: round-robin scheduler sharing one byte-wide Internet-checksum engine
// among N_REQ byte-stream requesters. Optional stall abort: define CKSCHED_TIMEOUT_EN.

module checksum_sched_chk (
  input logic clk,
  input logic rst,
  input logic chk_en,
  input logic parity,
  input logic ck_phase
);
  a_parity_phase: assert property (@(posedge clk) disable iff (rst) chk_en |-> (parity == ck_phase));
endmodule

module checksum_sched #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   grant,
  input  logic [N_REQ-1:0]   in_valid,
  input  logic [8*N_REQ-1:0] in_data,
  input  logic [N_REQ-1:0]   in_last,
  output logic [N_REQ-1:0]   in_ready,
  output logic [N_REQ-1:0]   done,
  output logic               err,
  output logic [15:0]        sum_out,
  output logic               ck_clr,
  output logic               ck_en,
  output logic [7:0]         ck_data,
  input  logic [15:0]        ck_sum,
  input  logic               ck_phase
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_PAD    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [PW-1:0]    ptr_r, ptr_s;
  logic [PW-1:0]    gidx_r, gidx_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic             parity_r, parity_s;
  logic             abort_r, abort_s;
  logic [N_REQ-1:0] done_r;
  logic             err_r;
  logic [15:0]      sum_r;

  logic             pick_found_s;
  logic [PW-1:0]    pick_idx_s;
  logic             valid_g_s;
  logic             last_g_s;
  logic [7:0]       data_g_s;
  logic             timeout_s;

  assign valid_g_s = in_valid[gidx_r];
  assign last_g_s  = in_last[gidx_r];
  assign data_g_s  = in_data[{gidx_r, 3'b000} +: 8];

  assign grant   = grant_r;
  assign done    = done_r;
  assign err     = err_r;
  assign sum_out = sum_r;

  // Round-robin pick: first set req at or after the pointer, wrapping at N_REQ.
  always_comb begin
    logic [PW:0]   sum_v;
    logic [PW-1:0] idx_v;
    pick_found_s = 1'b0;
    pick_idx_s   = {PW{1'b0}};
    sum_v        = {(PW+1){1'b0}};
    idx_v        = {PW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      sum_v        = {1'b0, ptr_r} + (PW+1)'(k);
      idx_v        = (sum_v >= (PW+1)'(N_REQ)) ? PW'(sum_v - (PW+1)'(N_REQ)) : PW'(sum_v);
      pick_idx_s   = (!pick_found_s && req[idx_v]) ? idx_v : pick_idx_s;
      pick_found_s = pick_found_s | req[idx_v];
    end
  end

`ifdef CKSCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall_r;

  assign timeout_s = (state_r == S_STREAM) && !valid_g_s && (stall_r == TW'(TIMEOUT_CYC - 1));

  // Consecutive stall counter, cleared by any accepted byte or leaving STREAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= {TW{1'b0}};
    end else if ((state_r != S_STREAM) || valid_g_s) begin
      stall_r <= {TW{1'b0}};
    end else begin
      stall_r <= stall_r + TW'(1);
    end
  end
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYC > 0);
  assign timeout_s        = 1'b0;
`endif

  // Next-state and engine/requester handshake decode.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    gidx_s   = gidx_r;
    grant_s  = grant_r;
    parity_s = parity_r;
    abort_s  = abort_r;
    in_ready = {N_REQ{1'b0}};
    ck_clr   = 1'b0;
    ck_en    = 1'b0;
    ck_data  = 8'h00;
    case (state_r)
      S_IDLE: begin
        if (pick_found_s) begin
          state_s = S_CLR;
          gidx_s  = pick_idx_s;
          grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          abort_s = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLR: begin
        ck_clr   = 1'b1;
        parity_s = 1'b0;
        state_s  = S_STREAM;
      end
      S_STREAM: begin
        in_ready = grant_r;
        ck_en    = valid_g_s;
        ck_data  = data_g_s;
        if (valid_g_s) begin
          parity_s = ~parity_r;
          if (last_g_s) begin
            // An odd total leaves a half word in the engine; flush it with a zero byte.
            state_s = parity_r ? S_DONE : S_PAD;
          end else begin
            state_s = S_STREAM;
          end
        end else if (timeout_s) begin
          state_s = S_DONE;
          abort_s = 1'b1;
        end else begin
          state_s = S_STREAM;
        end
      end
      S_PAD: begin
        ck_en    = 1'b1;
        ck_data  = 8'h00;
        parity_s = ~parity_r;
        state_s  = S_DONE;
      end
      S_DONE: begin
        ptr_s   = (gidx_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : gidx_r + PW'(1);
        grant_s = {N_REQ{1'b0}};
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
        grant_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // State registers; done/err/sum_out are registered off the DONE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      ptr_r    <= {PW{1'b0}};
      gidx_r   <= {PW{1'b0}};
      grant_r  <= {N_REQ{1'b0}};
      parity_r <= 1'b0;
      abort_r  <= 1'b0;
      done_r   <= {N_REQ{1'b0}};
      err_r    <= 1'b0;
      sum_r    <= 16'h0000;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      gidx_r   <= gidx_s;
      grant_r  <= grant_s;
      parity_r <= parity_s;
      abort_r  <= abort_s;
      done_r   <= (state_r == S_DONE) ? grant_r : {N_REQ{1'b0}};
      err_r    <= (state_r == S_DONE) && abort_r;
      if ((state_r == S_DONE) && !abort_r) begin
        sum_r <= ck_sum;
      end
    end
  end

  checksum_sched_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .chk_en   ((state_r == S_STREAM) || (state_r == S_PAD)),
    .parity   (parity_r),
    .ck_phase (ck_phase)
  );

endmodule

// File: tb/tb_checksum_sched.sv
// Self-checking bench for checksum_sched with a behavioural checksum engine and a done scoreboard.
module tb_checksum_sched;
  localparam int N = 2;
`ifdef CKSCHED_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [N-1:0]   in_valid = '0;
  logic [8*N-1:0] in_data  = '0;
  logic [N-1:0]   in_last  = '0;
  logic [N-1:0]   grant, in_ready, done;
  logic           err, ck_clr, ck_en, ck_phase;
  logic [15:0]    sum_out, ck_sum;
  logic [7:0]     ck_data;

  always #5 clk = ~clk;

  checksum_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .done(done), .err(err), .sum_out(sum_out),
    .ck_clr(ck_clr), .ck_en(ck_en), .ck_data(ck_data), .ck_sum(ck_sum), .ck_phase(ck_phase)
  );

  // Behavioural engine: big-endian byte pairs, ones'-complement add, complemented output.
  logic [15:0] eng_acc   = 16'h0000;
  logic [7:0]  eng_hi    = 8'h00;
  logic        eng_phase = 1'b0;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  always @(posedge clk) begin
    if (ck_clr) begin
      eng_acc   <= 16'h0000;
      eng_hi    <= 8'h00;
      eng_phase <= 1'b0;
    end else if (ck_en) begin
      if (!eng_phase) begin
        eng_hi    <= ck_data;
        eng_phase <= 1'b1;
      end else begin
        eng_acc   <= oc_add(eng_acc, {eng_hi, ck_data});
        eng_phase <= 1'b0;
      end
    end
  end
  assign ck_sum   = ~eng_acc;
  assign ck_phase = eng_phase;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic         err;
    logic [15:0]  sum;
  } exp_t;
  exp_t sb[$];
  logic [15:0] exp_hold = 16'h0000;

  // Scoreboard: every done pulse pops one expectation; between dones sum_out must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (done != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_mask", 32'(done), 32'(e.mask));
          check("done_err", 32'(err), 32'(e.err));
          check("done_sum", 32'(sum_out), 32'(e.sum));
          exp_hold = e.sum;
        end
      end else begin
        check("sum_hold", 32'(sum_out), 32'(exp_hold));
      end
    end
  end

  task automatic wait_grant(input int idx, input logic [N-1:0] mine, output bit ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!grant[idx] && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("grant", 32'(grant), 32'(mine));
    ok = (grant == mine);
  endtask

  task automatic run_job(input int idx, input int n, input logic [31:0] b, input logic [15:0] exp_sum);
    int w, lat, clr_cnt, other_bad;
    bit ok;
    logic [N-1:0] mine;
    exp_t e;
    mine = '0;
    mine[idx] = 1'b1;
    req[idx] = 1'b1;
    wait_grant(idx, mine, ok);
    if (ok) begin
      e.mask = mine; e.err = 1'b0; e.sum = exp_sum;
      sb.push_back(e);
      req[idx]  = 1'b0;
      clr_cnt   = int'(ck_clr);
      other_bad = 0;
      for (int i = 0; i < n; i++) begin
        in_valid[idx]         = 1'b1;
        in_data[idx*8 +: 8]   = b[31-8*i -: 8];
        in_last[idx]          = (i == n - 1);
        w = 0;
        while (!in_ready[idx] && w < 20) begin
          @(negedge clk);
          w++;
          clr_cnt   += int'(ck_clr);
          other_bad += int'((in_ready & ~mine) != '0);
        end
        check("byte_accept_wait", 32'(w < 20), 32'd1);
        @(negedge clk);
        clr_cnt   += int'(ck_clr);
        other_bad += int'((in_ready & ~mine) != '0);
      end
      in_valid[idx] = 1'b0;
      in_last[idx]  = 1'b0;
      if (n % 2 == 1) begin
        check("pad_en", 32'(ck_en), 32'd1);
        check("pad_data", 32'(ck_data), 32'd0);
      end
      lat = 1;
      while (!done[idx] && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check("done_latency", 32'(lat), (n % 2 == 1) ? 32'd3 : 32'd2);
      check("clr_count", 32'(clr_cnt), 32'd1);
      check("other_ready", 32'(other_bad), 32'd0);
      check("grant_at_done", 32'(grant), 32'd0);
    end
  endtask

  // Grant a job and feed one non-final byte, returning at the negedge after it is accepted.
  task automatic start_partial(input int idx, input logic [7:0] b0);
    int w;
    bit ok;
    logic [N-1:0] mine;
    mine = '0;
    mine[idx] = 1'b1;
    req[idx] = 1'b1;
    wait_grant(idx, mine, ok);
    req[idx] = 1'b0;
    in_valid[idx]       = 1'b1;
    in_data[idx*8 +: 8] = b0;
    in_last[idx]        = 1'b0;
    w = 0;
    while (!in_ready[idx] && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("partial_accept_wait", 32'(w < 20), 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    int          idx;
    int          n;
    logic [31:0] bytes;
    logic [15:0] exp_sum;
  } vec_t;
  vec_t vt[8];

  initial begin
    int cnt, lat;
    vt[0] = '{0, 4, 32'h12345678, 16'h9753};
    vt[1] = '{0, 3, 32'h12345600, 16'h97CB};
    vt[2] = '{1, 4, 32'hFFFF0001, 16'hFFFE};
    vt[3] = '{1, 2, 32'h12340000, 16'hEDCB};
    vt[4] = '{0, 1, 32'hAB000000, 16'h54FF};
    vt[5] = '{1, 4, 32'h00000000, 16'hFFFF};
    vt[6] = '{0, 4, 32'hFFFFFFFF, 16'h0000};
    vt[7] = '{1, 3, 32'h01020300, 16'hFBFD};

    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sum_out", 32'(sum_out), 32'd0);
    check("rst_ck_clr", 32'(ck_clr), 32'd0);
    check("rst_ck_en", 32'(ck_en), 32'd0);
    check("rst_ck_data", 32'(ck_data), 32'd0);
    rst = 1'b0;

    // Simultaneous requests: requester 0 first, requester 1 kept out until its turn.
    req = 2'b11;
    run_job(0, 2, 32'h12340000, 16'hEDCB);
    run_job(1, 2, 32'h56780000, 16'hA987);

    for (int v = 0; v < 8; v++) begin
      run_job(vt[v].idx, vt[v].n, vt[v].bytes, vt[v].exp_sum);
    end

    // Reset in the middle of a job: no done, then a clean job with a single clear.
    start_partial(0, 8'h12);
    in_data[7:0] = 8'h34;
    rst = 1'b1;
    exp_hold = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    in_valid = '0;
    in_last  = '0;
    check("rst_mid_grant", 32'(grant), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(done != '0);
    end
    check("rst_mid_no_done", 32'(cnt), 32'd0);
    run_job(0, 2, 32'h12340000, 16'hEDCB);

    // Stalled stream: aborts after TO idle cycles with the timeout build, waits forever otherwise.
    start_partial(1, 8'hAB);
    in_valid[1] = 1'b0;
`ifdef CKSCHED_TIMEOUT_EN
    begin
      exp_t e;
      e.mask = 2'b10; e.err = 1'b1; e.sum = 16'hEDCB;
      sb.push_back(e);
    end
    lat = 1;
    while (!done[1] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", 32'(lat), 32'(TO + 2));
    @(negedge clk);
`else
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      cnt += int'(done != '0);
    end
    check("no_timeout_done", 32'(cnt), 32'd0);
    check("stall_still_ready", 32'(in_ready), 32'b10);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
